// File: rtl/thejesvinii_axi.sv
// Tiny Tapeout wrapper: 16 x 4-bit register file behind a simplified AXI-Lite slave,
// with the last read value shown on a 7-segment digit. Define SEG_INVERT_EN for active-low segments.
module thejesvinii_axi #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef SEG_INVERT_EN
    localparam logic [6:0] SEG_MASK = 7'h7F;
`else
    localparam logic [6:0] SEG_MASK = 7'h00;
`endif

    typedef enum logic { R_IDLE, R_DATA } rd_state_e;
    typedef enum logic { W_IDLE, W_RESP } wr_state_e;

    rd_state_e         rd_state_q;
    wr_state_e         wr_state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [6:0]        seg_q;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              arvalid, rready, awvalid, wvalid;
    logic              wr_fire_d, rd_fire_d;
    logic              arready, rvalid, aw_w_ready;
    logic              unused_ok;

    assign addr    = ui_in[ADDR_W-1:0];
    assign wdata   = ui_in[4 +: DATA_W];
    assign arvalid = uio_in[0];
    assign rready  = uio_in[1];
    assign awvalid = uio_in[2];
    assign wvalid  = uio_in[3];
    assign unused_ok = &{1'b0, ena, uio_in[7:4]};

    // The address bus is shared, so a write handshake on this edge blocks the read.
    assign wr_fire_d  = (wr_state_q == W_IDLE) && awvalid && wvalid;
    assign rd_fire_d  = (rd_state_q == R_IDLE) && arvalid && !wr_fire_d;

    assign arready    = (rd_state_q == R_IDLE) && !wr_fire_d;
    assign rvalid     = (rd_state_q == R_DATA);
    assign aw_w_ready = (wr_state_q == W_IDLE);

    assign uio_out = {aw_w_ready, aw_w_ready, rvalid, arready, 4'b0000};
    assign uio_oe  = 8'hF0;
    assign uo_out  = {1'b0, seg_q};

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Display is stored already decoded, so uo_out comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            seg_q      <= 7'h3F ^ SEG_MASK;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (wr_fire_d) begin
                        mem_q[addr] <= wdata;
                        wr_state_q  <= W_RESP;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase

            case (rd_state_q)
                R_IDLE: begin
                    if (rd_fire_d) begin
                        seg_q      <= hex7(4'(mem_q[addr])) ^ SEG_MASK;
                        rd_state_q <= R_DATA;
                    end
                end
                default: begin
                    if (rready) begin
                        rd_state_q <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thejesvinii_axi.sv
// Self-checking bench for thejesvinii_axi: transaction-level model compared every cycle,
// plus directed reads/writes with literal display expectations.
module tb_thejesvinii_axi;

`ifdef SEG_INVERT_EN
    localparam logic [6:0] MASK = 7'h7F;
`else
    localparam logic [6:0] MASK = 7'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] addr = 4'h0, wdata = 4'h0;
    logic       arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic [7:0] ui_in, uio_in, uio_out, uio_oe, uo_out;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    assign ui_in  = {wdata, addr};
    assign uio_in = {4'b1010, wvalid, awvalid, rready, arvalid};

    thejesvinii_axi dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (1'b1),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .uo_out (uo_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lit(input logic [7:0] seg);
        return {1'b0, seg[6:0] ^ MASK};
    endfunction

    // Transaction model: memory contents, last value read, read outstanding, write cooldown.
    logic [3:0] m_mem [16];
    logic [3:0] m_last;
    bit         m_pend, m_wcool, m_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 4'h0;
            m_last  = 4'h0;
            m_pend  = 1'b0;
            m_wcool = 1'b0;
            m_ok    = 1'b1;
        end else begin
            bit w_acc, r_acc;
            w_acc = !m_wcool && awvalid && wvalid;
            r_acc = !m_pend && arvalid && !w_acc;
            if (r_acc) m_last = m_mem[addr];
            m_pend  = r_acc || (m_pend && !rready);
            m_wcool = w_acc;
            if (w_acc) m_mem[addr] = wdata;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            logic ar_exp;
            ar_exp = !m_pend && !(!m_wcool && awvalid && wvalid);
            chk("uio_out", uio_out, {!m_wcool, !m_wcool, m_pend, ar_exp, 4'b0000});
            chk("uo_out", uo_out, {1'b0, seg_tab[m_last] ^ MASK});
            chk("uio_oe", uio_oe, 8'hF0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        addr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_busy", {6'b0, uio_out[7:6]}, 8'h00);
        tick();
        $display("WRITE addr %h data %h", a, d);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp_uo, input int hold);
        int n;
        addr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!uio_out[5] && n < 8) begin
            tick();
            n++;
        end
        chk("rvalid_lat", {7'b0, uio_out[5]}, 8'h01);
        chk("rd_uo", uo_out, exp_uo);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rvalid_hold", {7'b0, uio_out[5]}, 8'h01);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        $display("READ  addr %h uo_out %h", a, uo_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("reset_uo", uo_out, lit(8'h3F));
        chk("reset_uio", uio_out, 8'hD0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();

        // 1: read of cleared memory
        do_read(4'h3, lit(8'h3F), 0);
        // 2: write then read back
        do_write(4'h3, 4'h4);
        do_read(4'h3, lit(8'h66), 0);
        // 3: unwritten address, rvalid held until rready
        do_read(4'h4, lit(8'h3F), 3);
        // 4: every address with value = address
        for (int i = 0; i < 16; i++) do_write(4'(i), 4'(i));
        for (int i = 0; i < 16; i++) do_read(4'(i), lit({1'b0, seg_tab[i]}), 0);
        chk("model_pin", {1'b0, seg_tab[m_last]}, 8'h71);

        // 5: AR collides with AW+W on the same edge; write wins
        addr = 4'h5; wdata = 4'h9; arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        #1 chk("ar_blocked", {7'b0, uio_out[4]}, 8'h00);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        arvalid = 1'b0;
        chk("coll_rvalid", {7'b0, uio_out[5]}, 8'h01);
        chk("coll_uo", uo_out, lit(8'h6F));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        $display("COLLIDE addr 5 data 9 uo_out %h", uo_out);

        // reset while a read response is pending
        addr = 4'h7; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("pre_rst_rvalid", {7'b0, uio_out[5]}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid", {7'b0, uio_out[5]}, 8'h00);
        chk("rst_uo", uo_out, lit(8'h3F));
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        $display("RESET mid-read, uio_out %h", uio_out);
        do_read(4'h7, lit(8'h3F), 0);

        // 6: half handshakes write nothing
        addr = 4'h2; wdata = 4'hF; awvalid = 1'b1;
        tick();
        chk("aw_only_ready", {6'b0, uio_out[7:6]}, 8'h03);
        awvalid = 1'b0; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        $display("HALF handshakes addr 2 data F");
        do_read(4'h2, lit(8'h3F), 0);

        // addresses wrap: write 15 then read it and its neighbour 0
        do_write(4'hF, 4'hB);
        do_read(4'hF, lit(8'h7C), 0);
        do_read(4'h0, lit(8'h3F), 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
